// File: rtl/pwm_rx.sv
`default_nettype none
// ============================================================================
// Module   : pwm_rx
// Function : PWM receiver that measures the high/low phase of each complete
//            period in clk cycles, with stuck-line timeout. Optional glitch
//            filter enabled by defining PWM_RX_GLITCH_FILTER_EN.
// Revision : 1.0
// ============================================================================
module pwm_rx #(
    parameter int CNT_WIDTH   = 16,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1000,
    parameter int FILTER_LEN  = 3
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 pwm_in,
    input  logic                 clear,
    output logic [CNT_WIDTH-1:0] on_cnt,
    output logic [CNT_WIDTH-1:0] off_cnt,
    output logic                 meas_valid,
    output logic                 overflow,
    output logic                 timeout,
    output logic                 stuck_level
);

    localparam logic [1:0]           c_ST_IDLE = 2'd0;
    localparam logic [1:0]           c_ST_HIGH = 2'd1;
    localparam logic [1:0]           c_ST_LOW  = 2'd2;
    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = '1;

    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
        $error("pwm_rx: SYNC_STAGES must be >= 2");
    end
    if (FILTER_LEN < 1) begin : g_bad_filter_len
        $error("pwm_rx: FILTER_LEN must be >= 1");
    end
    if (TIMEOUT < 0) begin : g_bad_timeout
        $error("pwm_rx: TIMEOUT must be >= 0");
    end

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_s;
    logic                   w_level;
    logic                   r_prev;
    logic                   r_rise;
    logic                   r_fall;
    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic                   r_sat;
    logic [CNT_WIDTH-1:0]   r_hi_lat;
    logic                   r_hi_ovf;
    logic [CNT_WIDTH-1:0]   r_on_cnt;
    logic [CNT_WIDTH-1:0]   r_off_cnt;
    logic                   r_meas_valid;
    logic                   r_overflow;
    logic                   r_timeout;
    logic                   r_stuck_level;
    logic                   w_to_reached;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], pwm_in};
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

`ifdef PWM_RX_GLITCH_FILTER_EN
    localparam int                  c_FCNT_W    = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [c_FCNT_W-1:0] c_FCNT_LAST = c_FCNT_W'(FILTER_LEN - 1);

    logic                r_filt;
    logic [c_FCNT_W-1:0] r_fcnt;

    // Level follows s only after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_filt <= 1'b0;
            r_fcnt <= '0;
        end else if (w_s == r_filt) begin
            r_fcnt <= '0;
        end else if (r_fcnt == c_FCNT_LAST) begin
            r_filt <= w_s;
            r_fcnt <= '0;
        end else begin
            r_fcnt <= r_fcnt + 1'b1;
        end
    end

    assign w_level = r_filt;
`else
    assign w_level = w_s;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_prev <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_prev <= w_level;
            r_rise <= w_level & ~r_prev;
            r_fall <= ~w_level & r_prev;
        end
    end

    assign w_to_reached = (TIMEOUT != 0) && (64'(r_cnt) == 64'(TIMEOUT));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (r_rise) w_state_nxt = c_ST_HIGH;
            c_ST_HIGH: begin
                if (r_fall)            w_state_nxt = c_ST_LOW;
                else if (w_to_reached) w_state_nxt = c_ST_IDLE;
            end
            c_ST_LOW: begin
                if (r_rise)            w_state_nxt = c_ST_HIGH;
                else if (w_to_reached) w_state_nxt = c_ST_IDLE;
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
        if (clear) w_state_nxt = c_ST_IDLE;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_cnt         <= '0;
            r_sat         <= 1'b0;
            r_hi_lat      <= '0;
            r_hi_ovf      <= 1'b0;
            r_on_cnt      <= '0;
            r_off_cnt     <= '0;
            r_meas_valid  <= 1'b0;
            r_overflow    <= 1'b0;
            r_timeout     <= 1'b0;
            r_stuck_level <= 1'b0;
        end else begin
            r_meas_valid <= 1'b0;
            if (clear) begin
                r_cnt         <= '0;
                r_sat         <= 1'b0;
                r_hi_lat      <= '0;
                r_hi_ovf      <= 1'b0;
                r_on_cnt      <= '0;
                r_off_cnt     <= '0;
                r_overflow    <= 1'b0;
                r_timeout     <= 1'b0;
                r_stuck_level <= 1'b0;
            end else begin
                case (r_state)
                    c_ST_IDLE: begin
                        if (r_rise || r_fall) r_timeout <= 1'b0;
                        if (r_rise) begin
                            r_cnt <= CNT_WIDTH'(1);
                            r_sat <= 1'b0;
                        end
                    end
                    c_ST_HIGH, c_ST_LOW: begin
                        if (r_state == c_ST_HIGH && r_fall) begin
                            r_hi_lat <= r_cnt;
                            r_hi_ovf <= r_sat;
                            r_cnt    <= CNT_WIDTH'(1);
                            r_sat    <= 1'b0;
                        end else if (r_state == c_ST_LOW && r_rise) begin
                            // Publishing rise also opens the next high phase.
                            r_on_cnt     <= r_hi_lat;
                            r_off_cnt    <= r_cnt;
                            r_overflow   <= r_hi_ovf | r_sat;
                            r_meas_valid <= 1'b1;
                            r_cnt        <= CNT_WIDTH'(1);
                            r_sat        <= 1'b0;
                        end else if (w_to_reached) begin
                            r_timeout     <= 1'b1;
                            r_stuck_level <= w_level;
                            r_cnt         <= '0;
                            r_sat         <= 1'b0;
                        end else if (r_cnt == c_CNT_MAX) begin
                            r_sat <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign on_cnt      = r_on_cnt;
    assign off_cnt     = r_off_cnt;
    assign meas_valid  = r_meas_valid;
    assign overflow    = r_overflow;
    assign timeout     = r_timeout;
    assign stuck_level = r_stuck_level;

endmodule
`default_nettype wire

// File: tb/tb_pwm_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_rx
// Function : Directed self-checking bench for pwm_rx (default and 8-bit/no
//            timeout instances).
// Revision : 1.0
// ============================================================================
module tb_pwm_rx;

`ifdef PWM_RX_GLITCH_FILTER_EN
    localparam int c_LAT = 4 + 3;
`else
    localparam int c_LAT = 4;
`endif

    typedef struct {
        logic [15:0] on_v;
        logic [15:0] off_v;
        logic        ovf;
        int          cyc;
    } meas_t;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    logic pwm_a = 1'b0;
    logic pwm_b = 1'b0;
    logic clear_a = 1'b0;
    logic clear_b = 1'b0;

    logic [15:0] on_a, off_a;
    logic        valid_a, ovf_a, to_a, stuck_a;
    logic [7:0]  on_b, off_b;
    logic        valid_b, ovf_b, to_b, stuck_b;

    int    cyc = 0;
    int    n_checks = 0;
    int    n_pass = 0;
    meas_t q_a[$];
    meas_t q_b[$];

    pwm_rx #(.CNT_WIDTH(16), .SYNC_STAGES(2), .TIMEOUT(1000), .FILTER_LEN(3)) u_dut (
        .clk(clk), .n_rst(n_rst), .pwm_in(pwm_a), .clear(clear_a),
        .on_cnt(on_a), .off_cnt(off_a), .meas_valid(valid_a),
        .overflow(ovf_a), .timeout(to_a), .stuck_level(stuck_a)
    );

    pwm_rx #(.CNT_WIDTH(8), .SYNC_STAGES(2), .TIMEOUT(0), .FILTER_LEN(3)) u_sat (
        .clk(clk), .n_rst(n_rst), .pwm_in(pwm_b), .clear(clear_b),
        .on_cnt(on_b), .off_cnt(off_b), .meas_valid(valid_b),
        .overflow(ovf_b), .timeout(to_b), .stuck_level(stuck_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid_a) q_a.push_back('{on_a, off_a, ovf_a, cyc});
        if (valid_b) q_b.push_back('{{8'd0, on_b}, {8'd0, off_b}, ovf_b, cyc});
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic phase_a(input logic lvl, input int n);
        pwm_a = lvl;
        tick(n);
    endtask

    task automatic phase_b(input logic lvl, input int n);
        pwm_b = lvl;
        tick(n);
    endtask

    task automatic pop_a(input string tag, input int e_on, input int e_off, input logic e_ovf);
        meas_t m;
        check({tag, "_present"}, 64'(q_a.size() > 0), 64'd1);
        if (q_a.size() > 0) begin
            m = q_a.pop_front();
            check({tag, "_on"}, 64'(m.on_v), 64'(e_on));
            check({tag, "_off"}, 64'(m.off_v), 64'(e_off));
            check({tag, "_ovf"}, 64'(m.ovf), 64'(e_ovf));
        end
    endtask

    task automatic pop_b(input string tag, input int e_on, input int e_off, input logic e_ovf);
        meas_t m;
        check({tag, "_present"}, 64'(q_b.size() > 0), 64'd1);
        if (q_b.size() > 0) begin
            m = q_b.pop_front();
            check({tag, "_on"}, 64'(m.on_v), 64'(e_on));
            check({tag, "_off"}, 64'(m.off_v), 64'(e_off));
            check({tag, "_ovf"}, 64'(m.ovf), 64'(e_ovf));
        end
    endtask

    task automatic check_zero_a(input string tag);
        check({tag, "_on"}, 64'(on_a), 64'd0);
        check({tag, "_off"}, 64'(off_a), 64'd0);
        check({tag, "_valid"}, 64'(valid_a), 64'd0);
        check({tag, "_ovf"}, 64'(ovf_a), 64'd0);
        check({tag, "_timeout"}, 64'(to_a), 64'd0);
        check({tag, "_stuck"}, 64'(stuck_a), 64'd0);
    endtask

    initial begin
        int e;
        tick(3);
        check_zero_a("reset");
        n_rst = 1'b1;
        tick(2);

        // Saturating instance: 400-cycle high in an 8-bit counter.
        phase_b(0, 20);
        phase_b(1, 400);
        phase_b(0, 10);
        phase_b(1, 20);
        pop_b("sat", 255, 10, 1'b1);
        phase_b(0, 30);
`ifndef PWM_RX_GLITCH_FILTER_EN
        phase_b(1, 1);
        phase_b(0, 1);
        phase_b(1, 10);
        pop_b("sat_recover", 20, 30, 1'b0);
        pop_b("min_phase", 1, 1, 1'b0);
`else
        phase_b(1, 10);
        pop_b("sat_recover", 20, 30, 1'b0);
`endif
        check("sat_no_extra", 64'(q_b.size()), 64'd0);

        // Steady 300/101 for 5 periods: 4 results.
        phase_a(0, 20);
        for (int p = 0; p < 5; p++) begin
            e = cyc;
            phase_a(1, 300);
            if (p == 0) begin
                check("first_rise_no_valid", 64'(q_a.size()), 64'd0);
            end else begin
                if (p == 1 && q_a.size() > 0) check("valid_latency", 64'(q_a[0].cyc - e), 64'(c_LAT));
                pop_a("steady", 300, 101, 1'b0);
            end
            phase_a(0, 101);
        end
        check("steady_count", 64'(q_a.size()), 64'd0);

        // Duty change mid-period.
        phase_a(1, 300);
        pop_a("period5", 300, 101, 1'b0);
        phase_a(0, 351);
        phase_a(1, 50);
        pop_a("mixed", 300, 351, 1'b0);
        phase_a(0, 351);

        // Stuck high for 1500 cycles.
        pwm_a = 1'b1;
        tick(c_LAT + 999);
        pop_a("new_duty", 50, 351, 1'b0);
        check("timeout_early", 64'(to_a), 64'd0);
        tick(1);
        check("timeout_set", 64'(to_a), 64'd1);
        check("stuck_level", 64'(stuck_a), 64'd1);
        tick(1500 - c_LAT - 1000);
        check("timeout_no_valid", 64'(q_a.size()), 64'd0);
        check("timeout_keep_on", 64'(on_a), 64'd50);
        phase_a(0, c_LAT + 2);
        check("timeout_cleared", 64'(to_a), 64'd0);
        phase_a(0, 100);
        phase_a(1, 200);
        check("resume_first_rise", 64'(q_a.size()), 64'd0);
        phase_a(0, 100);
        phase_a(1, 10);
        pop_a("resume", 200, 100, 1'b0);

        // Clear in the middle of LOW.
        phase_a(1, 50);
        phase_a(0, 30);
        clear_a = 1'b1;
        tick(1);
        clear_a = 1'b0;
        check_zero_a("clear");
        phase_a(0, 40);
        phase_a(1, 100);
        check("clear_first_rise", 64'(q_a.size()), 64'd0);
        phase_a(0, 60);
        phase_a(1, 10);
        pop_a("after_clear", 100, 60, 1'b0);

        // Asynchronous reset in the middle of LOW.
        phase_a(1, 90);
        phase_a(0, 30);
        n_rst = 1'b0;
        #1;
        check_zero_a("async_reset");
        tick(2);
        n_rst = 1'b1;
        phase_a(0, 40);
        phase_a(1, 120);
        check("reset_first_rise", 64'(q_a.size()), 64'd0);
        phase_a(0, 70);
        phase_a(1, 10);
        pop_a("after_reset", 120, 70, 1'b0);

`ifdef PWM_RX_GLITCH_FILTER_EN
        phase_a(1, 90);
        phase_a(0, 2);
        phase_a(1, 198);
        phase_a(0, 50);
        phase_a(1, 10);
        pop_a("glitch2", 300, 50, 1'b0);
        check("glitch2_no_extra", 64'(q_a.size()), 64'd0);
        phase_a(1, 90);
        phase_a(0, 3);
        phase_a(1, 10);
        pop_a("glitch3", 100, 3, 1'b0);
`endif

        tick(10);
        check("final_no_extra", 64'(q_a.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pwm_rx.md
# pwm_rx

PWM receiver / duty-cycle monitor: samples an asynchronous PWM line, measures the high (on) and low (off) phase lengths of each complete period in clk cycles, and publishes them with a one-cycle valid strobe. It sits on the feedback side of the PID controller, either closing a loop-back check on the team's PWM transmitter output or reading an external PWM source. It also flags a stuck line through a timeout.

## Interface
- CNT_WIDTH, 16, width of phase counters and result ports
- SYNC_STAGES, 2, input synchronizer depth (≥2)
- TIMEOUT, 1000, cycles without an edge before `timeout` asserts; 0 disables timeout
- FILTER_LEN, 3, glitch-filter length in cycles (used only with the macro, ≥1)

- clk  input  1  system clock
- n_rst  input  1  asynchronous active-low reset
- pwm_in  input  1  asynchronous PWM line
- clear  input  1  synchronous clear: abort measurement, zero results and flags
- on_cnt  output  CNT_WIDTH  high-phase length of last complete period
- off_cnt  output  CNT_WIDTH  low-phase length of last complete period
- meas_valid  output  1  one-cycle pulse when on_cnt/off_cnt update
- overflow  output  1  the published measurement saturated in either phase
- timeout  output  1  no edge for TIMEOUT cycles (level)
- stuck_level  output  1  line level when timeout fired

## Operation
- Reset values: all outputs 0, state IDLE, counter 0, synchronizer flops 0.
- pwm_in → SYNC_STAGES flops → s; prev <= s; rise = s & ~prev, fall = ~s & prev.
- FSM states:
  - IDLE: wait for rise; the partial period after reset/clear/timeout is discarded. rise → HIGH, cnt <= 1.
  - HIGH: cnt increments each cycle. fall → hi_lat <= cnt, hi_ovf <= sat, cnt <= 1, LOW.
  - LOW: cnt increments each cycle. rise → on_cnt <= hi_lat, off_cnt <= cnt, overflow <= hi_ovf | sat, meas_valid <= 1, cnt <= 1, HIGH.
- Result: on_cnt equals the exact number of cycles s was high; off_cnt the exact number it was low. A transmitter with a 300-cycle high and 101-cycle low reads on_cnt=300, off_cnt=101.
- Saturation: cnt holds at 2^CNT_WIDTH−1 and sets `sat` for the current phase. Saturation never wraps.
- Timeout (TIMEOUT≠0): if cnt reaches TIMEOUT in HIGH or LOW, then timeout <= 1, stuck_level <= s, and state goes to IDLE. on_cnt/off_cnt keep their last values and no meas_valid is issued. timeout clears on the next rise or fall of s.
- clear has priority over edges and timeout. It zeroes on_cnt, off_cnt, overflow, timeout, stuck_level and the counter, and moves to IDLE. meas_valid is 0 in that cycle.
- Reset mid-measurement: state is discarded immediately (async). The first valid comes after two rising edges.

## Timing
- Edge latency: a pwm_in transition sampled at clk edge k appears on s at edge k+SYNC_STAGES−1. rise/fall are registered one cycle later.
- meas_valid rises SYNC_STAGES+1 cycles after the clk edge that first samples the rising pwm_in. The result ports update in the same cycle and are held until the next update, clear, or reset.
- First meas_valid after IDLE comes at the second detected rising edge.
- Minimum resolvable phase: 1 cycle. Two edges in consecutive cycles are both handled.
- The rise that publishes a result also starts the next HIGH phase; there is no dead cycle between periods.

## Configuration
- PWM_RX_GLITCH_FILTER_EN defined: a filter sits between s and the edge detector. The filtered level changes only after FILTER_LEN consecutive identical samples of s. Pulses shorter than FILTER_LEN cycles are ignored and counted into the surrounding phase. Edge latency grows by FILTER_LEN cycles; phase lengths of accepted pulses are unchanged.
- Not defined: s feeds the edge detector directly, and FILTER_LEN is unused.

## Test plan
- Steady PWM, 300 high / 101 low, 5 periods → 4 meas_valid pulses, each on_cnt=300, off_cnt=101, overflow=0.
- Duty change to 50 high / 351 low mid-run → the next complete period reports 50/351, and the period in progress when the change applies is reported with its true mixed lengths.
- TIMEOUT=1000, line held high for 1500 cycles → timeout=1 and stuck_level=1 exactly 1000 cycles after the rise, no meas_valid; the next fall clears timeout, and valid resumes after two further rises.
- TIMEOUT=0, CNT_WIDTH=8, 400-cycle high / 10-cycle low → on_cnt=255, off_cnt=10, overflow=1.
- Assert clear and n_rst in the middle of a LOW phase → all outputs 0; the first meas_valid comes at the second rise afterwards.
- With PWM_RX_GLITCH_FILTER_EN defined and FILTER_LEN=3, a 2-cycle low glitch inside a 300-cycle high → no extra valid, on_cnt=300 (a 3-cycle glitch is accepted as a phase).
